kraken_dmmu: RTL and testbench
==============================

Name: kraken_dmmu

Overview:
- Responder for the core's data-side memory interface (d_addr/d_rd/d_wr/d_trd in; d_rd_data/d_miss/d_segfault out).
- Per access: per-thread base/limit segment check, a lookup in a direct-mapped write-through data cache, and fills or write-throughs over a single req/ack backing-memory port.
- A miss is reported to the core in the request cycle. The core replays the access later; the block never stalls the pipeline itself.

Parameters:
LINES, 64, number of one-word cache lines (power of two, >=2)
IDX_W, $clog2(LINES), line index width (derived)
TAG_W, 30-IDX_W, stored tag width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
d_addr  in  32  thread-virtual byte address (mem stage)
d_rd  in  1  load request
d_wr  in  1  store request
d_trd  in  3  requesting thread
d_wr_data  in  32  store data
d_rd_data  out  32  load data, registered
d_miss  out  1  access not accepted, replay (combinational, same cycle)
d_segfault  out  1  segment/alignment violation (combinational, same cycle)
cfg_wr  in  1  segment register write
cfg_trd  in  3  thread being configured
cfg_base  in  32  physical base
cfg_limit  in  32  segment size in bytes
mem_req  out  1  backing request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  physical word address (byte address, [1:0]=0)
mem_wdata  out  32  write data
mem_ack  in  1  one-cycle completion
mem_rdata  in  32  fill data, valid with mem_ack
busy  out  1  FSM not IDLE

Behaviour:
- Access = d_rd | d_wr. If both are set, treat as a store and ignore d_rd.
- Segfault is set when an access has d_addr[1:0]!=0 or d_addr >= limit[d_trd] (unsigned). It has priority over d_miss: d_miss=0, no cache or memory effect, d_rd_data holds.
- Physical address: paddr = base[d_trd] + d_addr, mod 2^32. idx = paddr[IDX_W+1:2]; tag = paddr[31:IDX_W+2].
- FSM states: IDLE, FILL, WRITE.
- IDLE, load hit: d_miss=0; d_rd_data <= line data at the next edge.
- IDLE, load miss: d_miss=1; latch paddr; go to FILL; assert mem_req=1, mem_we=0 from the next cycle.
- IDLE, store: d_miss=0 (accepted); latch paddr and data; go to WRITE with mem_req=1, mem_we=1. On a tag hit the line is updated at the same edge. No allocate on a store miss.
- FILL or WRITE, any new non-faulting access: d_miss=1, no side effects, even if it would hit.
- FILL + mem_ack: write line {valid, tag, mem_rdata}; go to IDLE. The replayed load hits later.
- WRITE + mem_ack: go to IDLE.
- mem_req and mem_addr/mem_we/mem_wdata stay stable from assertion until the ack cycle inclusive; mem_req drops the cycle after the ack.
- mem_ack received in IDLE is ignored.
- cfg_wr updates base/limit[cfg_trd] at the edge. An access in the same cycle to the same thread uses the old values.
- Reset values: state IDLE; all valid bits 0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; d_rd_data=0; busy=0; base[*]=0; limit[0]=32'hFFFF_FFFC; limit[1..7]=0.
- Reset during FILL or WRITE aborts the transaction: no line is written and mem_req=0 from the next cycle.
- Index wrap: the address with idx=LINES-1 and the address with idx=0 in the next tag are distinct lines with no aliasing.

Decomposition:
- Shared package kraken_mmu_pkg: dmmu_state_e {IDLE, FILL, WRITE}; typedef seg_t {base, limit}; constant NUM_TRD=8; reset limit for thread 0.
- One sub-module, kraken_dcache_array: valid/tag/data storage, one combinational read port, one write port, synchronous valid clear on rst.
- Segment check and FSM stay in kraken_dmmu.

Test Plan:
- Reset, cfg thread 1 base=0x1000 limit=0x100; d_rd trd1 addr 0x40 -> d_miss=1 same cycle, mem_req mem_we=0 mem_addr=0x1040; ack rdata=0xDEADBEEF -> replay: d_miss=0, next-cycle d_rd_data=0xDEADBEEF.
- trd1 d_rd addr 0x100 -> d_segfault=1, d_miss=0, no mem_req; addr 0x42 -> d_segfault=1.
- Store trd0 addr 0x8 data 0x12345678 after a fill of that line -> accepted, mem_we=1 mem_addr=0x8; then load 0x8 -> hit 0x12345678; a second access during WRITE -> d_miss=1.
- LINES=64: load 0x0 then 0x100 (same idx, different tag) -> both miss and both fill, and the second evicts the first; loads 0xFC and 0x100 occupy different idx with no conflict.
- rst asserted in the cycle after mem_req rises in FILL -> mem_req=0 next cycle; a late mem_ack is ignored; a load to the same address misses again.
- cfg_wr of trd2 limit=0x10 coinciding with a trd2 load at 0x8 -> segfault (old limit 0); the following cycle the same load -> miss and fill.

Source files
------------

// File: rtl/kraken_mmu_pkg.sv
// Shared types for the Kraken data-side MMU.
// FSM state encoding, segment record and reset constants.
package kraken_mmu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } dmmu_state_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
  } seg_t;

  localparam int          NUM_TRD    = 8;
  localparam logic [31:0] LIMIT0_RST = 32'hFFFF_FFFC;

endpackage

// File: rtl/kraken_dcache_array.sv
// Direct-mapped one-word-per-line storage for the data cache.
// One combinational read port, one write port, valid bits cleared on rst.
module kraken_dcache_array
  import kraken_mmu_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // A write racing reset is dropped so an aborted fill leaves nothing behind.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/kraken_dmmu.sv
// Data-side MMU: per-thread segment check, write-through cache,
// and a single req/ack backing port. Misses are replayed by the core.
module kraken_dmmu
  import kraken_mmu_pkg::*;
#(
  parameter int LINES = 64,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [2:0]  d_trd,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        d_miss,
  output logic        d_segfault,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_trd,
  input  logic [31:0] cfg_base,
  input  logic [31:0] cfg_limit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  dmmu_state_e state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  seg_t        seg_q [NUM_TRD];
  seg_t        seg_d [NUM_TRD];

  seg_t             cur_seg;
  logic             acc, is_st, segf, hit;
  logic [31:0]      paddr;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;

  logic             c_valid;
  logic [TAG_W-1:0] c_tag;
  logic [31:0]      c_data;
  logic             w_en;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_data;

  assign cur_seg = seg_q[d_trd];
  assign acc     = d_rd | d_wr;
  assign is_st   = d_wr;
  assign segf    = acc && ((d_addr[1:0] != 2'b00) ||
                           (d_addr >= cur_seg.limit));
  assign paddr   = cur_seg.base + d_addr;
  assign a_idx   = paddr[IDX_W+1:2];
  assign a_tag   = paddr[31:IDX_W+2];
  assign hit     = c_valid && (c_tag == a_tag);

  kraken_dcache_array #(
    .LINES (LINES)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (a_idx),
    .rd_valid (c_valid),
    .rd_tag   (c_tag),
    .rd_data  (c_data),
    .wr_en    (w_en),
    .wr_idx   (w_idx),
    .wr_tag   (w_tag),
    .wr_data  (w_data)
  );

  always_comb begin
    seg_d = seg_q;
    if (cfg_wr) begin
      seg_d[cfg_trd].base  = cfg_base;
      seg_d[cfg_trd].limit = cfg_limit;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    w_en        = 1'b0;
    w_idx       = a_idx;
    w_tag       = a_tag;
    w_data      = d_wr_data;
    unique case (state_q)
      IDLE: begin
        if (acc && !segf) begin
          if (is_st) begin
            state_d     = WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = paddr & 32'hFFFF_FFFC;
            mem_wdata_d = d_wr_data;
            w_en        = hit;
          end else if (hit) begin
            rd_data_d = c_data;
          end else begin
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = paddr & 32'hFFFF_FFFC;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          w_en      = 1'b1;
          w_idx     = mem_addr_q[IDX_W+1:2];
          w_tag     = mem_addr_q[31:IDX_W+2];
          w_data    = mem_rdata;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      for (int i = 0; i < NUM_TRD; i++) begin
        seg_q[i].base  <= '0;
        seg_q[i].limit <= (i == 0) ? LIMIT0_RST : 32'h0;
      end
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      seg_q       <= seg_d;
    end
  end

  // Any non-faulting access while a transaction is open is bounced.
  assign d_miss     = acc && !segf &&
                      ((state_q != IDLE) || (!is_st && !hit));
  assign d_segfault = segf;
  assign d_rd_data  = rd_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_kraken_dmmu.sv
// Self-checking bench for kraken_dmmu: word-level reference model
// compared every cycle, plus directed literal checks.
module tb_kraken_dmmu;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr;
  logic        d_rd;
  logic        d_wr;
  logic [2:0]  d_trd;
  logic [31:0] d_wr_data;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        d_segfault;
  logic        cfg_wr;
  logic [2:0]  cfg_trd;
  logic [31:0] cfg_base;
  logic [31:0] cfg_limit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  kraken_dmmu #(.LINES(LINES)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_addr     (d_addr),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_trd      (d_trd),
    .d_wr_data  (d_wr_data),
    .d_rd_data  (d_rd_data),
    .d_miss     (d_miss),
    .d_segfault (d_segfault),
    .cfg_wr     (cfg_wr),
    .cfg_trd    (cfg_trd),
    .cfg_base   (cfg_base),
    .cfg_limit  (cfg_limit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: one pending transaction, cache lines keyed by word address.
  bit          m_on = 1'b0;
  bit          m_busy;
  bit          m_fill;
  logic [31:0] m_maddr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdd;
  bit          m_lv [LINES];
  logic [31:0] m_la [LINES];
  logic [31:0] m_ld [LINES];
  logic [31:0] m_base [8];
  logic [31:0] m_lim [8];

  function automatic bit m_acc();
    return d_rd | d_wr;
  endfunction

  function automatic bit m_segf();
    return m_acc() && ((d_addr % 4) != 0 || d_addr >= m_lim[d_trd]);
  endfunction

  function automatic logic [31:0] m_pa();
    return (m_base[d_trd] + d_addr) & 32'hFFFF_FFFC;
  endfunction

  function automatic int m_line(input logic [31:0] a);
    return int'((a / 4) % LINES);
  endfunction

  function automatic bit m_hit();
    int ln;
    ln = m_line(m_pa());
    return m_lv[ln] && (m_la[ln] == m_pa());
  endfunction

  always @(posedge clk) begin
    int ln;
    if (rst) begin
      m_on    = 1'b1;
      m_busy  = 1'b0;
      m_fill  = 1'b0;
      m_maddr = '0;
      m_wdata = '0;
      m_rdd   = '0;
      for (int i = 0; i < LINES; i++) m_lv[i] = 1'b0;
      for (int t = 0; t < 8; t++) begin
        m_base[t] = '0;
        m_lim[t]  = (t == 0) ? 32'hFFFF_FFFC : 32'h0;
      end
    end else if (m_on) begin
      ln = m_line(m_pa());
      if (!m_busy) begin
        if (m_acc() && !m_segf()) begin
          if (d_wr) begin
            if (m_hit()) m_ld[ln] = d_wr_data;
            m_busy  = 1'b1;
            m_fill  = 1'b0;
            m_maddr = m_pa();
            m_wdata = d_wr_data;
          end else if (m_hit()) begin
            m_rdd = m_ld[ln];
          end else begin
            m_busy  = 1'b1;
            m_fill  = 1'b1;
            m_maddr = m_pa();
          end
        end
      end else if (mem_ack) begin
        if (m_fill) begin
          ln       = m_line(m_maddr);
          m_lv[ln] = 1'b1;
          m_la[ln] = m_maddr;
          m_ld[ln] = mem_rdata;
        end
        m_busy = 1'b0;
      end
      if (cfg_wr) begin
        m_base[cfg_trd] = cfg_base;
        m_lim[cfg_trd]  = cfg_limit;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("d_segfault", d_segfault, m_segf());
      chk("d_miss", d_miss,
          m_acc() && !m_segf() && (m_busy || (!d_wr && !m_hit())));
      chk("mem_req", mem_req, m_busy);
      chk("busy", busy, m_busy);
      chk("d_rd_data", d_rd_data, m_rdd);
      if (m_busy) begin
        chk("mem_we", mem_we, !m_fill);
        chk("mem_addr", mem_addr, m_maddr);
        if (!m_fill) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_addr    = '0;
    d_trd     = '0;
    d_wr_data = '0;
    cfg_wr    = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic nx();
    cyc();
    clr();
    #1;
  endtask

  task automatic rd(input logic [2:0] t, input logic [31:0] a);
    d_rd   = 1'b1;
    d_trd  = t;
    d_addr = a;
    #1;
  endtask

  task automatic do_ack(input logic [31:0] data);
    for (int k = 0; k < 20 && !mem_req; k++) cyc();
    n_tests++;
    if (!mem_req) begin
      n_fail++;
      $display("FAIL ack_wait: mem_req %b want 1 within 20 cycles", mem_req);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    cyc();
    mem_ack = 1'b0;
    #1;
  endtask

  task automatic fill(input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] data);
    rd(t, a);
    chk("fill_miss", d_miss, 1'b1);
    nx();
    do_ack(data);
  endtask

  task automatic hitchk(input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] exp);
    rd(t, a);
    chk("hit_miss", d_miss, 1'b0);
    nx();
    chk("hit_data", d_rd_data, exp);
  endtask

  initial begin
    clr();
    rst       = 1'b1;
    cfg_trd   = '0;
    cfg_base  = '0;
    cfg_limit = '0;
    mem_rdata = '0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rd_data", d_rd_data, 32'h0);
    chk("rst_busy", busy, 1'b0);

    cfg_wr    = 1'b1;
    cfg_trd   = 3'd1;
    cfg_base  = 32'h1000;
    cfg_limit = 32'h100;
    nx();

    rd(3'd1, 32'h40);
    chk("t1_miss", d_miss, 1'b1);
    nx();
    chk("t1_req", mem_req, 1'b1);
    chk("t1_we", mem_we, 1'b0);
    chk("t1_addr", mem_addr, 32'h1040);
    do_ack(32'hDEAD_BEEF);
    chk("t1_req_drop", mem_req, 1'b0);
    hitchk(3'd1, 32'h40, 32'hDEAD_BEEF);

    rd(3'd1, 32'h100);
    chk("seg_limit", d_segfault, 1'b1);
    chk("seg_nomiss", d_miss, 1'b0);
    nx();
    chk("seg_noreq", mem_req, 1'b0);
    rd(3'd1, 32'h42);
    chk("seg_align", d_segfault, 1'b1);
    nx();

    fill(3'd0, 32'h8, 32'hAAAA_0000);
    d_wr      = 1'b1;
    d_trd     = 3'd0;
    d_addr    = 32'h8;
    d_wr_data = 32'h1234_5678;
    #1;
    chk("st_accept", d_miss, 1'b0);
    nx();
    chk("st_req", mem_req, 1'b1);
    chk("st_we", mem_we, 1'b1);
    chk("st_addr", mem_addr, 32'h8);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    rd(3'd0, 32'h8);
    chk("busy_miss", d_miss, 1'b1);
    nx();
    do_ack(32'h0);
    hitchk(3'd0, 32'h8, 32'h1234_5678);

    fill(3'd0, 32'h0, 32'h1111_0000);
    fill(3'd0, 32'h100, 32'h2222_0000);
    hitchk(3'd0, 32'h100, 32'h2222_0000);
    rd(3'd0, 32'h0);
    chk("evicted", d_miss, 1'b1);
    nx();
    do_ack(32'h1111_0000);
    fill(3'd0, 32'hFC, 32'h3333_0000);
    fill(3'd0, 32'h100, 32'h2222_0000);
    hitchk(3'd0, 32'hFC, 32'h3333_0000);
    hitchk(3'd0, 32'h100, 32'h2222_0000);

    rd(3'd0, 32'h200);
    chk("ab_miss", d_miss, 1'b1);
    nx();
    chk("ab_req", mem_req, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("ab_req_drop", mem_req, 1'b0);
    chk("ab_busy", busy, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h9999_9999;
    nx();
    chk("late_ack", mem_req, 1'b0);
    rd(3'd0, 32'h200);
    chk("ab_remiss", d_miss, 1'b1);
    nx();
    do_ack(32'h7777_7777);
    hitchk(3'd0, 32'h200, 32'h7777_7777);

    cfg_wr    = 1'b1;
    cfg_trd   = 3'd2;
    cfg_base  = 32'h0;
    cfg_limit = 32'h10;
    rd(3'd2, 32'h8);
    chk("cfg_old_seg", d_segfault, 1'b1);
    nx();
    rd(3'd2, 32'h8);
    chk("cfg_new_seg", d_segfault, 1'b0);
    chk("cfg_new_miss", d_miss, 1'b1);
    nx();
    do_ack(32'h55AA_55AA);
    hitchk(3'd2, 32'h8, 32'h55AA_55AA);

    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
